// File: rtl/fetch_stage.sv
// Fetch stage with F/D pipeline latch: owns the PC, runs a single-outstanding
// req/ack handshake to instruction memory, and parks a stalled fetch in a skid.
module fetch_stage #(
  parameter int unsigned PC_W = 12,
  parameter logic [31:0] NOP  = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            imem_ack,
  output logic [31:0]     ir_fd,
  output logic [PC_W-1:0] pc_fd,
  output logic            valid_fd,
  output logic            dx_bubble
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] addr_q;
  logic            req_q;
  logic [31:0]     ir_q;
  logic [PC_W-1:0] pcfd_q;
  logic            valid_q;
  logic [31:0]     skid_ir_q;
  logic [PC_W-1:0] skid_pc_q;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      ir_q      <= NOP;
      pcfd_q    <= '0;
      valid_q   <= 1'b0;
      skid_ir_q <= NOP;
      skid_pc_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            // Only reachable right after reset: launch the first request.
            req_q <= 1'b1;
            if (redirect) begin
              pc_q    <= redirect_pc;
              addr_q  <= redirect_pc;
              ir_q    <= NOP;
              valid_q <= 1'b0;
            end else begin
              addr_q <= pc_q;
            end
          end else if (redirect) begin
            ir_q      <= NOP;
            valid_q   <= 1'b0;
            pc_q      <= redirect_pc;
            skid_ir_q <= NOP;
            skid_pc_q <= '0;
            if (imem_ack) begin
              addr_q <= redirect_pc;
            end else begin
              state_q <= DRAIN;
            end
          end else if (imem_ack) begin
            pc_q <= pc_inc;
            if (stall) begin
              skid_ir_q <= imem_data;
              skid_pc_q <= pc_q;
              req_q     <= 1'b0;
              state_q   <= HOLD;
            end else begin
              ir_q    <= imem_data;
              pcfd_q  <= pc_q;
              valid_q <= 1'b1;
              addr_q  <= pc_inc;
            end
          end else if (!stall) begin
            ir_q    <= NOP;
            valid_q <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect) begin
            ir_q      <= NOP;
            valid_q   <= 1'b0;
            pc_q      <= redirect_pc;
            addr_q    <= redirect_pc;
            req_q     <= 1'b1;
            skid_ir_q <= NOP;
            skid_pc_q <= '0;
            state_q   <= FETCH;
          end else if (!stall) begin
            ir_q      <= skid_ir_q;
            pcfd_q    <= skid_pc_q;
            valid_q   <= 1'b1;
            skid_ir_q <= NOP;
            skid_pc_q <= '0;
            addr_q    <= pc_q;
            req_q     <= 1'b1;
            state_q   <= FETCH;
          end
        end

        DRAIN: begin
          ir_q    <= NOP;
          valid_q <= 1'b0;
          if (redirect) begin
            pc_q <= redirect_pc;
          end
          // Orphan ack retires the stale request; the newest target is issued.
          if (imem_ack) begin
            addr_q  <= redirect ? redirect_pc : pc_q;
            state_q <= FETCH;
          end
        end

        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_fd     = ir_q;
  assign pc_fd     = pcfd_q;
  assign valid_fd  = valid_q;
  assign dx_bubble = stall | redirect;

endmodule
